// File: rtl/mem_arbiter_pkg.sv
// Shared types and default sizes for the fetch/data memory arbiter.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEFAULT     = 16;
    localparam int DATA_W_DEFAULT     = 16;
    localparam int STARVE_MAX_DEFAULT = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Counts consecutive cycles in which a waiting fetch lost to a data access.
// Saturates at STARVE_MAX, at which point the arbiter lets fetch win.
module starve_counter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
    parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             f_req,
    input  logic             f_gnt,
    input  logic             d_gnt,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(STARVE_MAX);

    assign at_max = (count == MAX_CNT);

    always_ff @(posedge CLK) begin
        if (rst) begin
            count <= '0;
        end else if (!f_req || f_gnt) begin
            count <= '0;
        end else if (d_gnt && !at_max) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port, 1-cycle-latency memory between instruction fetch
// and the data stage, with a halt handshake that drains the fetch path.
//
//   state  | meaning
//   RUN    | fetch and data both eligible (fetch blocked while halt_req=1)
//   DRAIN  | fetch blocked, waiting for any fetch read data to return
//   HALTED | fetch path quiescent, halted=1; data still served
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              halt_req,
    output logic              halted,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    arb_state_t       state, state_next;
    logic [CNT_W-1:0] starve_cnt;
    logic             starve_max;
    logic             fetch_open;
    logic             f_rv_q, d_rv_q;

    starve_counter #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_starve (
        .CLK    (CLK),
        .rst    (rst),
        .f_req  (f_req),
        .f_gnt  (f_gnt),
        .d_gnt  (d_gnt),
        .count  (starve_cnt),
        .at_max (starve_max)
    );

    always_ff @(posedge CLK) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Fetch is always a read, so a fetch grant this cycle is the only way a
    // fetch rvalid can be pending for the next cycle.
    always_comb begin
        f_gnt      = 1'b0;
        d_gnt      = 1'b0;
        state_next = state;
        fetch_open = (state == RUN) && !halt_req;

        if (!rst) begin
            if (f_req && fetch_open && (starve_max || !d_req)) begin
                f_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end

        case (state)
            RUN: begin
                if (halt_req) state_next = DRAIN;
            end
            DRAIN: begin
                if (!halt_req)  state_next = RUN;
                else if (!f_gnt) state_next = HALTED;
            end
            HALTED: begin
                if (!halt_req) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        mem_en    = f_gnt | d_gnt;
        mem_we    = d_gnt & d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (f_gnt) begin
            mem_addr = f_addr;
        end else if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            f_rv_q <= 1'b0;
            d_rv_q <= 1'b0;
        end else begin
            f_rv_q <= f_gnt;
            d_rv_q <= d_gnt & ~d_we;
        end
    end

    // Masking with rst drops a read whose data would land in a reset cycle.
    assign f_rvalid = f_rv_q & ~rst;
    assign d_rvalid = d_rv_q & ~rst;
    assign f_rdata  = f_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid ? mem_rdata : '0;
    assign halted   = (state == HALTED);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, memory word width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, maximum consecutive fetch losses before fetch is forced to win.
REQ-004 SHALL have port CLK  in  1  single clock, all state updates on the rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports f_req in 1, f_addr in ADDR_W: instruction-fetch read request and address.
REQ-007 SHALL have ports f_gnt out 1, f_rvalid out 1, f_rdata out DATA_W: fetch grant, read-data valid, read data.
REQ-008 SHALL have ports d_req in 1, d_we in 1, d_addr in ADDR_W, d_wdata in DATA_W: data-stage request, write enable, address, write data.
REQ-009 SHALL have ports d_gnt out 1, d_rvalid out 1, d_rdata out DATA_W: data grant, read-data valid, read data.
REQ-010 SHALL have ports halt_req in 1 (stop new fetches) and halted out 1 (fetch path quiescent).
REQ-011 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_rdata in DATA_W: single-port memory with 1-cycle read latency.

Function
REQ-012 SHALL issue at most one memory access per cycle; mem_en = f_gnt | d_gnt.
REQ-013 SHALL compute grants combinationally in cycle T; the memory command SHALL be driven in T from the granted requester's address/we/wdata.
REQ-014 SHALL assert the granted requester's rvalid in T+1 for a granted read, with rdata = mem_rdata; no rvalid for a granted write.
REQ-015 SHALL give d_req priority over f_req unless the starvation counter equals STARVE_MAX, in which case f_req SHALL win.
REQ-016 Starvation counter (width clog2(STARVE_MAX+1)) SHALL increment when f_req=1 and d_gnt=1, clear on f_gnt=1 or f_req=0, and saturate at STARVE_MAX.
REQ-017 Requesters SHALL hold req and operands until gnt; a request is consumed in the cycle gnt=1.
REQ-018 FSM states RUN, DRAIN, HALTED; f_gnt SHALL be 0 in DRAIN and HALTED, and in RUN whenever halt_req=1.
REQ-019 RUN -> DRAIN when halt_req=1 at a clock edge.
REQ-020 DRAIN -> HALTED when no fetch rvalid is pending for the next cycle; DRAIN -> RUN if halt_req=0.
REQ-021 HALTED -> RUN when halt_req=0; halted SHALL be 1 only in HALTED.
REQ-022 Data accesses SHALL be granted in all three states.
REQ-023 When the starvation counter is STARVE_MAX and fetch is blocked by halt, data SHALL win and the counter SHALL hold.
REQ-024 mem_we SHALL equal d_we when d_gnt=1, else 0; mem_addr/mem_wdata SHALL be 0 when mem_en=0.

Reset
REQ-025 In any cycle with rst=1, all grants, rvalids, mem_en and mem_we SHALL be 0 and reads in flight SHALL be discarded (no rvalid the following cycle).
REQ-026 After reset: state RUN, starvation counter 0, f_rdata/d_rdata 0, halted 0.
REQ-027 Reset asserted mid-DRAIN or in HALTED SHALL return to RUN regardless of halt_req.

Structure
REQ-028 State enum (RUN/DRAIN/HALTED) and default widths SHALL live in the shared parameter package.
REQ-029 The starvation counter SHALL be a sub-module, starve_counter; grant logic and FSM SHALL stay in mem_arbiter.

Verification
REQ-030 f_req only, f_addr=0x0003, memory[3]=0x5208 -> f_gnt same cycle, f_rvalid next cycle with f_rdata=0x5208.
REQ-031 f_req and d_req (read, addr 0x0010) together for one cycle -> d_gnt=1, f_gnt=0; f_gnt next cycle once d_req drops.
REQ-032 d_req held 8 cycles with f_req held -> d_gnt for 4 cycles, f_gnt on cycle 5, counter 0, d_gnt resumes.
REQ-033 d_we=1, d_addr=0x0007, d_wdata=0x0007, then d_req read of 0x0007 -> mem_we=1 once, no d_rvalid for write, read returns 0x0007.
REQ-034 halt_req=1 during fetch read -> f_gnt 0 immediately, f_rvalid delivered, halted=1 two cycles later; data read still served; halt_req=0 -> halted=0 and f_gnt resumes next cycle.
REQ-035 rst=1 one cycle after a granted fetch read -> no f_rvalid, state RUN, halted=0.
